// File: rtl/writeback_regfile_if.sv
// rtl/writeback_regfile_if.sv - commit/read bundle between the memory stage, decode and the write-back register file
//
// master (upstream stage / bench): drives valid, icode, cnd, rA, rB, valE, valM, mem_error
//                                  and observes valA, valB, stat, halted, retired
// slave  (writeback_regfile):      the mirror image
interface writeback_regfile_if;
    logic        valid;
    logic [3:0]  icode;
    logic        cnd;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        mem_error;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [2:0]  stat;
    logic        halted;
    logic [63:0] retired;

    modport master (
        output valid, icode, cnd, rA, rB, valE, valM, mem_error,
        input  valA, valB, stat, halted, retired
    );

    modport slave (
        input  valid, icode, cnd, rA, rB, valE, valM, mem_error,
        output valA, valB, stat, halted, retired
    );
endinterface

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - Y86-64 write-back stage, register file, status latch and retired counter
//
// clk : rising-edge clock
// rst : synchronous active-high reset
// bus : writeback_regfile_if.slave
//       in : valid, icode, cnd, rA, rB, valE, valM, mem_error
//       out: valA, valB (combinational decode reads), stat, halted, retired
module writeback_regfile #(
    parameter logic [63:0] RSP_INIT = 64'd4095
) (
    input  logic                 clk,
    input  logic                 rst,
    writeback_regfile_if.slave   bus
);
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // Entry 15 exists only so a source of F indexes a slot that is held at
    // zero forever; it is never selected as a destination.
    logic [63:0] regs [0:15];
    logic [2:0]  stat_q;
    logic [63:0] retired_q;

    logic [3:0] dst_e;
    logic [3:0] dst_m;
    logic [3:0] src_a;
    logic [3:0] src_b;

    always_comb begin
        dst_e = RNONE;
        case (bus.icode)
            4'h2:                      dst_e = bus.cnd ? bus.rB : RNONE;
            4'h3, 4'h6:                dst_e = bus.rB;
            4'h8, 4'h9, 4'hA, 4'hB:    dst_e = RRSP;
            default:                   dst_e = RNONE;
        endcase
    end

    always_comb begin
        dst_m = RNONE;
        if (bus.icode == 4'h5 || bus.icode == 4'hB)
            dst_m = bus.rA;
    end

    always_comb begin
        src_a = RNONE;
        case (bus.icode)
            4'h2, 4'h4, 4'h6, 4'hA:    src_a = bus.rA;
            4'h9, 4'hB:                src_a = RRSP;
            default:                   src_a = RNONE;
        endcase
    end

    always_comb begin
        src_b = RNONE;
        case (bus.icode)
            4'h4, 4'h5, 4'h6:          src_b = bus.rB;
            4'h8, 4'h9, 4'hA, 4'hB:    src_b = RRSP;
            default:                   src_b = RNONE;
        endcase
    end

    // No bypass: decode sees the register state as of the last edge.
    assign bus.valA    = regs[src_a];
    assign bus.valB    = regs[src_b];
    assign bus.stat    = stat_q;
    assign bus.halted  = (stat_q != STAT_AOK);
    assign bus.retired = retired_q;

    // Exception priority: bad opcode, then bad address, then halt.
    logic live;
    logic is_ins;
    logic is_adr;
    logic is_hlt;
    logic commit;

    assign live   = bus.valid && (stat_q == STAT_AOK);
    assign is_ins = (bus.icode > 4'hB);
    assign is_adr = !is_ins && bus.mem_error;
    assign is_hlt = !is_ins && !is_adr && (bus.icode == 4'h0);
    // HLT counts as a commit; its destinations decode to F so it writes nothing.
    assign commit = live && !is_ins && !is_adr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++)
                regs[i] <= (4'(i) == RRSP) ? RSP_INIT : 64'd0;
            stat_q    <= STAT_AOK;
            retired_q <= 64'd0;
        end else begin
            if (commit) begin
                // valM takes priority so popq %rsp leaves the popped value.
                for (int i = 0; i < 15; i++) begin
                    if (dst_m == 4'(i))
                        regs[i] <= bus.valM;
                    else if (dst_e == 4'(i))
                        regs[i] <= bus.valE;
                end
                retired_q <= retired_q + 64'd1;
            end
            if (live) begin
                if (is_ins)
                    stat_q <= STAT_INS;
                else if (is_adr)
                    stat_q <= STAT_ADR;
                else if (is_hlt)
                    stat_q <= STAT_HLT;
            end
        end
    end
endmodule
